// File: rtl/keccak_pkg.sv
// Shared sizing constants and state encoding for the Keccak block gatherer.
package keccak_pkg;

  localparam int KECCAK_WORD_W  = 32;
  localparam int KECCAK_WORDS   = 16;
  localparam int KECCAK_BLOCK_W = KECCAK_WORD_W * KECCAK_WORDS;
  localparam int KECCAK_NUM_W   = 6;

  localparam logic [KECCAK_NUM_W-1:0] KECCAK_NUM_AUTO = 6'd63;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/keccak_gather_mask.sv
// Fill-mask tracking, write acceptance, completion detect and optional auto-increment
// pointer (enabled by KECCAK_GATHER_AUTOINC_EN).
module keccak_gather_mask
  import keccak_pkg::*;
#(
  parameter int WORDS = KECCAK_WORDS,
  parameter int NUM_W = KECCAK_NUM_W,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             handshake,
  input  logic             wr_req,
  input  logic [NUM_W-1:0] num,
  output logic             wr_ok,
  output logic [IDX_W-1:0] wr_idx,
  output logic             full,
  output logic [WORDS-1:0] fill_mask
);

  logic [WORDS-1:0] mask_reg;
  logic [WORDS-1:0] mask_next;

`ifdef KECCAK_GATHER_AUTOINC_EN
  logic [IDX_W-1:0] wp_reg;
  logic             auto_wr;

  always_comb begin
    wr_ok   = 1'b0;
    auto_wr = 1'b0;
    wr_idx  = num[IDX_W-1:0];
    if (wr_req) begin
      if (num < NUM_W'(WORDS)) begin
        wr_ok = 1'b1;
      end else if (num == KECCAK_NUM_AUTO) begin
        wr_ok   = 1'b1;
        auto_wr = 1'b1;
        wr_idx  = wp_reg;
      end
    end
  end

  // Pointer wraps naturally at the slot count.
  always_ff @(posedge clk) begin
    if (reset || clear || handshake) begin
      wp_reg <= '0;
    end else if (auto_wr) begin
      wp_reg <= wp_reg + 1'b1;
    end
  end
`else
  always_comb begin
    wr_ok  = wr_req && (num < NUM_W'(WORDS));
    wr_idx = num[IDX_W-1:0];
  end
`endif

  always_comb begin
    mask_next = mask_reg;
    if (wr_ok) begin
      mask_next[wr_idx] = 1'b1;
    end
  end

  // Completion is only raised by an accepted write, so HOLD is entered on that edge.
  assign full = wr_ok && (&mask_next);

  always_ff @(posedge clk) begin
    if (reset || clear || handshake) begin
      mask_reg <= '0;
    end else begin
      mask_reg <= mask_next;
    end
  end

  assign fill_mask = mask_reg;

endmodule

// File: rtl/keccak_gather.sv
// Assembles a 512-bit Keccak block from 32-bit words and hands it off with valid/ready.
// Optional KECCAK_GATHER_AUTOINC_EN adds num==63 auto-increment slot addressing.
module keccak_gather
  import keccak_pkg::*;
#(
  parameter int WORD_W = KECCAK_WORD_W,
  parameter int WORDS  = KECCAK_WORDS,
  parameter int NUM_W  = KECCAK_NUM_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [NUM_W-1:0]        num,
  input  logic [WORD_W-1:0]       in32,
  input  logic                    clear,
  output logic [WORD_W*WORDS-1:0] out512,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORDS-1:0]        fill_mask,
  output logic                    wr_err
);

  localparam int IDX_W = $clog2(WORDS);

  logic [0:0]       state_reg;
  logic             wr_req;
  logic             wr_ok;
  logic [IDX_W-1:0] wr_idx;
  logic             full;
  logic             handshake;
  logic             err_reg;

  assign wr_req    = en && (state_reg == ST_FILL) && !clear;
  assign handshake = (state_reg == ST_HOLD) && out_ready && !clear;

  keccak_gather_mask #(
    .WORDS (WORDS),
    .NUM_W (NUM_W),
    .IDX_W (IDX_W)
  ) u_mask (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .handshake (handshake),
    .wr_req    (wr_req),
    .num       (num),
    .wr_ok     (wr_ok),
    .wr_idx    (wr_idx),
    .full      (full),
    .fill_mask (fill_mask)
  );

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_reg <= ST_FILL;
    end else if (state_reg == ST_FILL) begin
      if (full) begin
        state_reg <= ST_HOLD;
      end
    end else if (out_ready) begin
      state_reg <= ST_FILL;
    end
  end

  // Any strobe that does not land in a slot is a rejected write, including writes in HOLD.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      err_reg <= 1'b0;
    end else if (en && !wr_ok) begin
      err_reg <= 1'b1;
    end
  end

  assign out_valid = (state_reg == ST_HOLD);
  assign wr_err    = err_reg;

  // Slots keep stale data across handshakes; only reset zeroes them.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_slot
    logic [WORD_W-1:0] slot_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        slot_reg <= '0;
      end else if (wr_ok && (wr_idx == IDX_W'(gi))) begin
        slot_reg <= in32;
      end
    end

    assign out512[gi*WORD_W +: WORD_W] = slot_reg;
  end

endmodule

// File: tb/tb_keccak_gather.sv
// Directed self-checking bench for keccak_gather; covers KECCAK_GATHER_AUTOINC_EN when defined.
module tb_keccak_gather;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic [5:0]   num = '0;
  logic [31:0]  in32 = '0;
  logic         clear = 1'b0;
  logic [511:0] out512;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [15:0]  fill_mask;
  logic         wr_err;

  int total = 0;
  int bad = 0;
  logic [511:0] exp_blk;

  always #5 clk = ~clk;

  keccak_gather dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .num       (num),
    .in32      (in32),
    .clear     (clear),
    .out512    (out512),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill_mask (fill_mask),
    .wr_err    (wr_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] n, input logic [31:0] d);
    en = 1'b1; num = n; in32 = d;
    tick();
    en = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    chk("rst_out512", out512, '0);
    chk("rst_valid", out_valid, 0);
    chk("rst_mask", fill_mask, 0);
    chk("rst_err", wr_err, 0);

    // 1: in-order fill and handshake
    for (int i = 0; i < 16; i++) begin
      wr(6'(i), 32'h1000_0000 + i);
      if (i == 14) chk("t1_valid_early", out_valid, 0);
    end
    chk("t1_valid", out_valid, 1);
    chk("t1_slot0", out512[31:0], 32'h1000_0000);
    chk("t1_slot15", out512[511:480], 32'h1000_000F);
    chk("t1_mask_full", fill_mask, 16'hFFFF);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_hs_valid", out_valid, 0);
    chk("t1_hs_mask", fill_mask, 0);

    // 2: out-of-order fill with a rewrite, out_ready held high
    out_ready = 1'b1;
    wr(6'd15, 32'h2000_000F);
    wr(6'd3, 32'h3333_0001);
    wr(6'd0, 32'h2000_0000);
    chk("t2_ready_in_fill", out_valid, 0);
    wr(6'd1, 32'h2000_0001);
    wr(6'd2, 32'h2000_0002);
    wr(6'd3, 32'h3333_0002);
    for (int i = 4; i < 14; i++) wr(6'(i), 32'h2000_0000 + i);
    chk("t2_mask_partial", fill_mask, 16'hBFFF);
    chk("t2_valid_early", out_valid, 0);
    wr(6'd14, 32'h2000_000E);
    chk("t2_valid", out_valid, 1);
    chk("t2_slot3", out512[127:96], 32'h3333_0002);
    chk("t2_slot15", out512[511:480], 32'h2000_000F);
    chk("t2_slot14", out512[479:448], 32'h2000_000E);
    tick();
    chk("t2_hs_valid", out_valid, 0);
    chk("t2_hs_mask", fill_mask, 0);
    out_ready = 1'b0;

    // 3: out-of-range writes, write in HOLD, write on handshake edge
    wr(6'd16, 32'hBAD0_0016);
    chk("t3_err16", wr_err, 1);
    chk("t3_mask16", fill_mask, 0);
    wr(6'd40, 32'hBAD0_0040);
    chk("t3_mask40", fill_mask, 0);
    chk("t3_slot0_kept", out512[31:0], 32'h2000_0000);
    for (int i = 0; i < 16; i++) begin
      wr(6'(i), 32'h4000_0000 + i);
      exp_blk[32*i +: 32] = 32'h4000_0000 + i;
    end
    chk("t3_valid", out_valid, 1);
    wr(6'd5, 32'hDEAD_BEEF);
    chk("t3_hold_data", out512, exp_blk);
    chk("t3_hold_valid", out_valid, 1);
    chk("t3_hold_err", wr_err, 1);
    out_ready = 1'b1;
    wr(6'd0, 32'hDEAD_0000);
    out_ready = 1'b0;
    chk("t3_hs_valid", out_valid, 0);
    chk("t3_hs_drop", out512, exp_blk);
    chk("t3_hs_mask", fill_mask, 0);

    // 4: clear with a simultaneous write
    for (int i = 0; i < 8; i++) wr(6'(i), 32'h5000_0000 + i);
    chk("t4_mask8", fill_mask, 16'h00FF);
    clear = 1'b1;
    wr(6'd9, 32'h5000_0009);
    clear = 1'b0;
    chk("t4_clr_mask", fill_mask, 0);
    chk("t4_clr_err", wr_err, 0);
    chk("t4_clr_valid", out_valid, 0);
    chk("t4_slot9_kept", out512[319:288], 32'h4000_0009);
    for (int i = 0; i < 16; i++) begin
      wr(6'(15 - i), 32'h6000_0000 + i);
      exp_blk[32*(15-i) +: 32] = 32'h6000_0000 + i;
    end
    chk("t4_valid", out_valid, 1);
    chk("t4_block", out512, exp_blk);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_hs_valid", out_valid, 0);

    // 5: reset mid-block
    for (int i = 0; i < 10; i++) wr(6'(i), 32'h7000_0000 + i);
    wr(6'd16, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_out512", out512, '0);
    chk("t5_valid", out_valid, 0);
    chk("t5_mask", fill_mask, 0);
    chk("t5_err", wr_err, 0);
    for (int i = 0; i < 16; i++) begin
      wr(6'(i), 32'h8000_0000 + i);
      if (i == 14) chk("t5_valid_early", out_valid, 0);
    end
    chk("t5_valid_16", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t5_hs_valid", out_valid, 0);

`ifdef KECCAK_GATHER_AUTOINC_EN
    // 6: auto-increment pointer
    for (int i = 0; i < 17; i++) begin
      wr(6'd63, 32'h9000_0000 + i);
      if (i == 14) chk("t6_mask15", fill_mask, 16'h7FFF);
      if (i == 15) begin
        chk("t6_valid", out_valid, 1);
        chk("t6_err_none", wr_err, 0);
      end
    end
    chk("t6_err17", wr_err, 1);
    chk("t6_slot0", out512[31:0], 32'h9000_0000);
    chk("t6_slot15", out512[511:480], 32'h9000_000F);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t6_hs_valid", out_valid, 0);
    wr(6'd63, 32'hAAAA_0000);
    chk("t6_wp0_slot", out512[31:0], 32'hAAAA_0000);
    chk("t6_wp0_mask", fill_mask, 16'h0001);
    wr(6'd5, 32'hAAAA_0005);
    wr(6'd63, 32'hAAAA_0001);
    chk("t6_wp1_slot", out512[63:32], 32'hAAAA_0001);
    chk("t6_wp1_mask", fill_mask, 16'h0023);
`else
    // 6: num 63 is plain out of range without the pointer
    wr(6'd63, 32'hAAAA_0000);
    chk("t6_err63", wr_err, 1);
    chk("t6_mask63", fill_mask, 0);
    chk("t6_slot0_kept", out512[31:0], 32'h8000_0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
